// File: rtl/mem_arbiter.sv
// mem_arbiter -- sole owner of the CPU's byte-wide RAM/IO port.
//
// Two requesters share the port: instruction fetch (IF, 4-byte reads) and
// the load/store buffer (LS, 1/2/4-byte reads or writes). Grants alternate
// round-robin when both request together. Each access is split into single
// bytes, little-endian, and completes with a one-cycle done pulse.
//
// Optional build macro: MEM_ARB_IF_ABORT_EN adds the clr input, which drops
// an in-flight IF read (and suppresses an IF grant in IDLE).
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   rdy              global enable (low = pause, mem_wr forced low)
//   clr              (MEM_ARB_IF_ABORT_EN only) IF flush
//   inst_req/addr    IF read request (level) and address
//   inst_done/data   IF completion pulse and fetched word
//   ls_req/wr/len    LS request, 1 = store, length code (0:1B 1:2B 2/3:4B)
//   ls_addr/wdata    LS byte address and store data
//   ls_done/rdata    LS completion pulse and zero-extended load data
//   mem_din          RAM read data (one-cycle latency)
//   mem_dout/a/wr    RAM write data, address, write strobe
//   io_buffer_full   IO sink cannot accept a write
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
`ifdef MEM_ARB_IF_ABORT_EN
  input  logic              clr,
`endif
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_done,
  output logic [31:0]       inst_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_len,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

  state_t              state_reg, state_next;
  logic                last_ls_reg, last_ls_next;     // last grant: 0 = IF, 1 = LS
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [1:0]          last_idx_reg, last_idx_next;   // index of final byte (N-1)
  logic [31:0]         wdata_reg, wdata_next;
  logic [2:0]          issue_cnt_reg, issue_cnt_next; // next byte to put on the bus
  logic [1:0]          cap_cnt_reg, cap_cnt_next;     // next read byte to capture
  logic                v1_reg, v1_next;               // a read address went out last edge
  logic                v2_reg, v2_next;               // its data is on mem_din now
  logic [31:0]         acc_reg, acc_next;
  logic                inst_done_reg, inst_done_next;
  logic                ls_done_reg, ls_done_next;
  logic [31:0]         inst_data_reg, inst_data_next;
  logic [31:0]         ls_rdata_reg, ls_rdata_next;
  logic [ADDR_W-1:0]   mem_a_reg, mem_a_next;
  logic [7:0]          mem_dout_reg, mem_dout_next;
  logic                mem_wr_reg, mem_wr_next;

  logic                flush;
`ifdef MEM_ARB_IF_ABORT_EN
  assign flush = clr;
`else
  assign flush = 1'b0;
`endif

  function automatic logic [1:0] len_last(input logic [1:0] len);
    // Code 3 is treated like a word access.
    case (len)
      2'd0:    len_last = 2'd0;
      2'd1:    len_last = 2'd1;
      default: len_last = 2'd3;
    endcase
  endfunction

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    is_io = (a[17:16] == IO_HI);
  endfunction

  logic [ADDR_W-1:0] byte_addr;
  logic [31:0]       acc_merged;
  logic [7:0]        wbyte;
  logic              more_to_issue;
  logic              if_ok;

  assign byte_addr     = addr_reg + ADDR_W'(issue_cnt_reg);
  assign acc_merged    = acc_reg | ({24'd0, mem_din} << {cap_cnt_reg, 3'b000});
  assign wbyte         = 8'(wdata_reg >> {issue_cnt_reg[1:0], 3'b000});
  assign more_to_issue = (issue_cnt_reg <= {1'b0, last_idx_reg});
  assign if_ok         = inst_req & ~flush;

  always_comb begin
    state_next     = state_reg;
    last_ls_next   = last_ls_reg;
    addr_next      = addr_reg;
    last_idx_next  = last_idx_reg;
    wdata_next     = wdata_reg;
    issue_cnt_next = issue_cnt_reg;
    cap_cnt_next   = cap_cnt_reg;
    v1_next        = v1_reg;
    v2_next        = v2_reg;
    acc_next       = acc_reg;
    inst_done_next = inst_done_reg;
    ls_done_next   = ls_done_reg;
    inst_data_next = inst_data_reg;
    ls_rdata_next  = ls_rdata_reg;
    mem_a_next     = mem_a_reg;
    mem_dout_next  = mem_dout_reg;
    mem_wr_next    = 1'b0;

    if (!rdy) begin
      // Paused: read data in the pipe is dropped; on resume the first
      // uncaptured byte is fetched again.
      if (state_reg == IF_RD || state_reg == LS_RD) begin
        v1_next        = 1'b0;
        v2_next        = 1'b0;
        issue_cnt_next = {1'b0, cap_cnt_reg};
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (if_ok && (!ls_req || last_ls_reg)) begin
            state_next     = IF_RD;
            last_ls_next   = 1'b0;
            addr_next      = inst_addr;
            last_idx_next  = 2'd3;
            mem_a_next     = inst_addr;
            issue_cnt_next = 3'd1;
            cap_cnt_next   = 2'd0;
            v1_next        = 1'b1;
            v2_next        = 1'b0;
            acc_next       = 32'd0;
          end else if (ls_req) begin
            last_ls_next  = 1'b1;
            addr_next     = ls_addr;
            last_idx_next = len_last(ls_len);
            wdata_next    = ls_wdata;
            mem_a_next    = ls_addr;
            cap_cnt_next  = 2'd0;
            v2_next       = 1'b0;
            acc_next      = 32'd0;
            if (ls_wr) begin
              state_next    = LS_WR;
              mem_dout_next = ls_wdata[7:0];
              v1_next       = 1'b0;
              if (is_io(ls_addr) && io_buffer_full) begin
                issue_cnt_next = 3'd0;
              end else begin
                mem_wr_next    = 1'b1;
                issue_cnt_next = 3'd1;
              end
            end else begin
              state_next     = LS_RD;
              issue_cnt_next = 3'd1;
              v1_next        = 1'b1;
            end
          end
        end

        IF_RD, LS_RD: begin
          if (state_reg == IF_RD && flush) begin
            state_next = IDLE;
            v1_next    = 1'b0;
            v2_next    = 1'b0;
          end else begin
            v2_next = v1_reg;
            if (more_to_issue) begin
              mem_a_next     = byte_addr;
              issue_cnt_next = issue_cnt_reg + 3'd1;
              v1_next        = 1'b1;
            end else begin
              v1_next = 1'b0;
            end
            if (v2_reg) begin
              acc_next     = acc_merged;
              cap_cnt_next = cap_cnt_reg + 2'd1;
              if (cap_cnt_reg == last_idx_reg) begin
                state_next = DONE;
                v1_next    = 1'b0;
                v2_next    = 1'b0;
                if (state_reg == IF_RD) begin
                  inst_data_next = acc_merged;
                  inst_done_next = 1'b1;
                end else begin
                  ls_rdata_next = acc_merged;
                  ls_done_next  = 1'b1;
                end
              end
            end
          end
        end

        LS_WR: begin
          if (!more_to_issue) begin
            state_next   = DONE;
            ls_done_next = 1'b1;
          end else if (!(is_io(byte_addr) && io_buffer_full)) begin
            mem_a_next     = byte_addr;
            mem_dout_next  = wbyte;
            mem_wr_next    = 1'b1;
            issue_cnt_next = issue_cnt_reg + 3'd1;
          end
        end

        DONE: begin
          // A flush here has nothing left to cancel: done drops anyway.
          inst_done_next = 1'b0;
          ls_done_next   = 1'b0;
          state_next     = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_ls_reg   <= 1'b0;
      addr_reg      <= '0;
      last_idx_reg  <= 2'd0;
      wdata_reg     <= 32'd0;
      issue_cnt_reg <= 3'd0;
      cap_cnt_reg   <= 2'd0;
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      acc_reg       <= 32'd0;
      inst_done_reg <= 1'b0;
      ls_done_reg   <= 1'b0;
      inst_data_reg <= 32'd0;
      ls_rdata_reg  <= 32'd0;
      mem_a_reg     <= '0;
      mem_dout_reg  <= 8'd0;
      mem_wr_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_ls_reg   <= last_ls_next;
      addr_reg      <= addr_next;
      last_idx_reg  <= last_idx_next;
      wdata_reg     <= wdata_next;
      issue_cnt_reg <= issue_cnt_next;
      cap_cnt_reg   <= cap_cnt_next;
      v1_reg        <= v1_next;
      v2_reg        <= v2_next;
      acc_reg       <= acc_next;
      inst_done_reg <= inst_done_next;
      ls_done_reg   <= ls_done_next;
      inst_data_reg <= inst_data_next;
      ls_rdata_reg  <= ls_rdata_next;
      mem_a_reg     <= mem_a_next;
      mem_dout_reg  <= mem_dout_next;
      mem_wr_reg    <= mem_wr_next;
    end
  end

  assign inst_done = inst_done_reg;
  assign inst_data = inst_data_reg;
  assign ls_done   = ls_done_reg;
  assign ls_rdata  = ls_rdata_reg;
  assign mem_a     = mem_a_reg;
  assign mem_dout  = mem_dout_reg;
  assign mem_wr    = mem_wr_reg;

endmodule
